// File: rtl/regfile_pkg.sv
// Shared constants and width helpers for the scoreboarded register file.
// The pending-count width is derived here so top and scoreboard always agree.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // One extra bit so the count can reach the full depth without wrapping.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Busy-bit scoreboard: RAW/WAW hazard detection, busy set/clear and pending count.
// Optional REGFILE_BYPASS_EN: a same-cycle writeback releases its busy bit before the hazard check.
module register_file_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          rs,
    input  logic [ADDR_W-1:0]          rt,
    input  logic [ADDR_W-1:0]          rd,
    input  logic                       writeEnable,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueRd,
    output logic                       stall,
    output logic [cnt_w(ADDR_W)-1:0]   pendCnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = cnt_w(ADDR_W);

    logic [DEPTH-1:0] busy_q, busy_d, busy_eff;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             set_en, set_new, clr_real;

    always_comb begin
        busy_eff = busy_q;
`ifdef REGFILE_BYPASS_EN
        if (writeEnable) begin
            busy_eff[rd] = 1'b0;
        end
`endif
    end

    assign stall = issueValid && (busy_eff[rs] || busy_eff[rt] || busy_eff[issueRd]);

    assign set_en   = issueValid && !stall && !((ZERO_REG != 0) && (issueRd == '0));
    assign set_new  = set_en && !busy_q[issueRd];
    // A clear that coincides with a set of the same register is overridden by the set.
    assign clr_real = writeEnable && busy_q[rd] && !(set_en && (issueRd == rd));

    always_comb begin
        busy_d = busy_q;
        if (writeEnable) begin
            busy_d[rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[issueRd] = 1'b1;
        end
    end

    always_comb begin
        pend_d = pend_q;
        case ({set_new, clr_real})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    assign pendCnt = pend_q;

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with busy-bit scoreboard; reads are combinational.
// Optional REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          rs,
    input  logic [ADDR_W-1:0]          rt,
    input  logic [ADDR_W-1:0]          rd,
    input  logic [DATA_W-1:0]          busW,
    input  logic                       writeEnable,
    input  logic                       issueValid,
    input  logic [ADDR_W-1:0]          issueRd,
    output logic [DATA_W-1:0]          busA,
    output logic [DATA_W-1:0]          busB,
    output logic                       stall,
    output logic [cnt_w(ADDR_W)-1:0]   pendCnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;

    assign wr_en = writeEnable && !((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd] <= busW;
        end
    end

    always_comb begin
        busA = regs_q[rs];
        if ((ZERO_REG != 0) && (rs == '0)) begin
            busA = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (rd == rs)) begin
            busA = busW;
        end
`endif
        if (reset) begin
            busA = '0;
        end
    end

    always_comb begin
        busB = regs_q[rt];
        if ((ZERO_REG != 0) && (rt == '0)) begin
            busB = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (rd == rt)) begin
            busB = busW;
        end
`endif
        if (reset) begin
            busB = '0;
        end
    end

    register_file_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .writeEnable (writeEnable),
        .issueValid  (issueValid),
        .issueRd     (issueRd),
        .stall       (stall),
        .pendCnt     (pendCnt)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Directed scenarios plus randomized traffic against an array/popcount reference model.
module tb_register_file_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rs, rt, rd, issueRd;
    logic [DW-1:0] busW, busA, busB;
    logic          writeEnable, issueValid, stall;
    logic [AW:0]   pendCnt;

    always #5 clk = ~clk;

    register_file_sb dut (
        .clk         (clk),
        .reset       (reset),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .busW        (busW),
        .writeEnable (writeEnable),
        .issueValid  (issueValid),
        .issueRd     (issueRd),
        .busA        (busA),
        .busB        (busB),
        .stall       (stall),
        .pendCnt     (pendCnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit m_eff(input logic [AW-1:0] a);
        return m_busy[a] && !(BYP && writeEnable && (rd == a));
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && writeEnable && (rd == a)) return busW;
        return m_regs[a];
    endfunction

    function automatic bit m_stall();
        return issueValid && (m_eff(rs) || m_eff(rt) || m_eff(issueRd));
    endfunction

    function automatic int m_pend();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_reset();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic iv, input logic [AW-1:0] ia);
        rs = a; rt = b; writeEnable = we; rd = wa; busW = wd;
        issueValid = iv; issueRd = ia;
    endtask

    // Compare outputs mid-cycle, advance the model, then cross the edge.
    task automatic tick();
        bit st;
        #4;
        check_eq("busA",    busA,    m_read(rs));
        check_eq("busB",    busB,    m_read(rt));
        check_eq("stall",   stall,   m_stall());
        check_eq("pendCnt", pendCnt, m_pend());
        st = m_stall();
        if (writeEnable && rd != 0) m_regs[rd] = busW;
        if (writeEnable) m_busy[rd] = 1'b0;
        if (issueValid && !st && issueRd != 0) m_busy[issueRd] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(5, 6, 1'b0, 0, '0, 1'b0, 0);
        m_reset();
        #2;
        check_eq("rst_pend",  pendCnt, 0);
        check_eq("rst_stall", stall,   0);
        check_eq("rst_busA",  busA,    0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Plain write then read, and r0 stays zero.
        drive(0, 0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
        tick();
        drive(5, 0, 1'b1, 0, 32'hCAFEF00D, 1'b0, 0);
        #1;
        check_eq("r5_read", busA, 32'hDEADBEEF);
        tick();
        drive(0, 5, 1'b0, 0, '0, 1'b0, 0);
        #1;
        check_eq("r0_read", busA, 0);
        tick();

        // Issue to r8, then a dependent issue must stall.
        drive(0, 0, 1'b0, 0, '0, 1'b1, 8);
        tick();
        check_eq("busy8_pend", pendCnt, 1);
        drive(8, 0, 1'b0, 0, '0, 1'b1, 9);
        #1;
        check_eq("raw_stall", stall, 1);
        tick();
        check_eq("stall_pend", pendCnt, 1);

        // Writeback to busy r8 while a reader of r8 issues.
        drive(8, 0, 1'b1, 8, 32'h12345678, 1'b1, 10);
        #1;
        check_eq("wb_stall", stall, !BYP);
        check_eq("wb_busA",  busA,  BYP ? 32'h12345678 : 32'h0);
        tick();

        // Simultaneous set and clear of r3.
        drive(0, 0, 1'b0, 0, '0, 1'b1, 3);
        tick();
        drive(0, 0, 1'b1, 3, 32'h33, 1'b1, 3);
        tick();

        // Writeback to non-busy r9.
        drive(0, 0, 1'b1, 9, 32'h0909_0909, 1'b0, 0);
        tick();
        drive(9, 0, 1'b0, 0, '0, 1'b0, 0);
        #1;
        check_eq("r9_read", busA, 32'h0909_0909);
        tick();

        // Release everything, then fill the scoreboard.
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, 1'b1, AW'(i), DW'(i * 32'h0101), 1'b0, 0);
            tick();
        end
        check_eq("pend_empty", pendCnt, 0);
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, 1'b0, 0, '0, 1'b1, AW'(i));
            tick();
        end
        check_eq("pend_full", pendCnt, 31);

        // Asynchronous reset mid-sequence with a pending writeback.
        drive(5, 7, 1'b1, 6, 32'hBAD0BAD0, 1'b1, 5);
        #1;
        reset = 1'b1;
        #1;
        check_eq("amid_pend",  pendCnt, 0);
        check_eq("amid_stall", stall,   0);
        check_eq("amid_busA",  busA,    0);
        check_eq("amid_busB",  busB,    0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(6, 5, 1'b0, 0, '0, 1'b0, 0);
        tick();

        // Randomized traffic, biased to a small register window for hazards.
        for (int n = 0; n < 1500; n++) begin
            logic [AW-1:0] a, b, wa, ia;
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wa = AW'($urandom_range(0, 7));
            ia = AW'($urandom_range(0, 7));
            drive(a, b, ($urandom_range(0, 1) == 1), wa, DW'($urandom),
                  ($urandom_range(0, 9) < 6), ia);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
